// File: rtl/spi_arbiter_pkg.sv
// spi_arb_pkg: shared definitions for the SPI arbiter.
//   state_t      - FSM encoding, also exported on the dbg_state port
//   DEF_*        - default parameter values for NUM_REQ, DATA_W and TIMEOUT
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: bundles the requester side and the SPI-master side of the
// arbiter.
//
// Handshake semantics (one place for all of them):
//   req[i] is a level request that the requester holds until it sees gnt[i].
//   gnt[i] is a one-cycle pulse meaning "your frame has been latched"; the
//   requester may change req/req_tx_data from the next cycle on.
//   rsp_valid[i] is a one-cycle pulse; rsp_data and rsp_err are meaningful
//   only in that cycle. There is no back-pressure on responses.
//   spi_start is a one-cycle pulse; spi_tx_data/spi_sel stay stable until the
//   arbiter returns to idle. spi_done is a one-cycle pulse that qualifies
//   spi_rx_data. spi_busy=1 blocks arbitration.
//
// Modports:
//   master - the arbiter (drives gnt, rsp_*, spi_start, spi_tx_data, spi_sel)
//   slave  - the environment (requesters plus SPI master)
interface spi_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_tx_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      spi_start;
    logic [DATA_W-1:0]         spi_tx_data;
    logic [IDX_W-1:0]          spi_sel;
    logic                      spi_busy;
    logic                      spi_done;
    logic [DATA_W-1:0]         spi_rx_data;

    modport master (
        input  req, req_tx_data, spi_busy, spi_done, spi_rx_data,
        output gnt, rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, spi_sel
    );

    modport slave (
        output req, req_tx_data, spi_busy, spi_done, spi_rx_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, spi_sel
    );

endinterface

// File: rtl/spi_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req      - request vector
//   last_idx - index of the requester served last
//   valid    - at least one request is present
//   idx      - first requesting index at or after (last_idx+1) mod NUM_REQ
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the nearest
    // requesting index after last_idx is the one left in idx.
    always_comb begin
        valid    = |req;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_idx) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between NUM_REQ requesters.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - spi_arbiter_if.master (requester and SPI-master signals)
//   dbg_state - current FSM state
// Flow: IDLE (round-robin pick, blocked while spi_busy) -> START (one cycle:
// gnt + spi_start) -> WAIT (until spi_done or TIMEOUT cycles) -> RESP (one
// cycle: rsp_valid) -> IDLE. Every output is a register.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.master bus,
    output state_t        dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_data_r;
    logic               rsp_err_r;
    logic               spi_start_r;
    logic [DATA_W-1:0]  spi_tx_r;
    logic [IDX_W-1:0]   spi_sel_r;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [DATA_W-1:0]  arb_frame;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [NUM_REQ-1:0] idx_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req      (bus.req),
        .last_idx (last_idx),
        .valid    (arb_valid),
        .idx      (arb_idx)
    );

    // Frame mux and one-hot decodes use constant slices only.
    always_comb begin
        arb_frame  = '0;
        arb_onehot = '0;
        idx_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                arb_frame     = bus.req_tx_data[i*DATA_W +: DATA_W];
                arb_onehot[i] = 1'b1;
            end
            if (idx == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            last_idx    <= IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
            gnt_r       <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            spi_start_r <= 1'b0;
            spi_tx_r    <= '0;
            spi_sel_r   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid && !bus.spi_busy) begin
                        idx         <= arb_idx;
                        spi_sel_r   <= arb_idx;
                        spi_tx_r    <= arb_frame;
                        gnt_r       <= arb_onehot;
                        spi_start_r <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    gnt_r       <= '0;
                    spi_start_r <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done is tested first so it wins over a same-cycle timeout.
                    if (bus.spi_done) begin
                        rsp_valid_r <= idx_onehot;
                        rsp_data_r  <= bus.spi_rx_data;
                        rsp_err_r   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid_r <= idx_onehot;
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    rsp_data_r  <= '0;
                    rsp_err_r   <= 1'b0;
                    last_idx    <= idx;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.spi_start   = spi_start_r;
    assign bus.spi_tx_data = spi_tx_r;
    assign bus.spi_sel     = spi_sel_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench for spi_arbiter with a response scoreboard
// and an expected-grant queue. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    always #5 clk = ~clk;

    spi_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    logic [DW-1:0] tx_tab [NR];
    assign bus.req_tx_data = {tx_tab[3], tx_tab[2], tx_tab[1], tx_tab[0]};

    spi_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    // response item: {idx[1:0], err, data[7:0]}
    logic [10:0] exp_q[$];
    logic [1:0]  gnt_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic [1:0] idx, input logic err, input logic [7:0] data);
        exp_q.push_back({idx, err, data});
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"},       32'(bus.gnt), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data), 0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
        chk({tag, "_spi_start"}, 32'(bus.spi_start), 0);
        chk({tag, "_spi_tx"},    32'(bus.spi_tx_data), 0);
        chk({tag, "_spi_sel"},   32'(bus.spi_sel), 0);
        chk({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
    endtask

    // Waits for a grant and checks it against the head of gnt_q.
    task automatic grant_step(input int exp_lat);
        int         cyc;
        logic [1:0] ei;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.gnt == '0 && cyc < 20);
        chk("grant_latency", cyc, exp_lat);
        if (gnt_q.size() == 0) begin
            chk("gnt_q_nonempty", 0, 1);
        end else begin
            ei = gnt_q.pop_front();
            chk("gnt",         32'(bus.gnt), 32'(4'b0001 << ei));
            chk("spi_start",   32'(bus.spi_start), 1);
            chk("spi_sel",     32'(bus.spi_sel), 32'(ei));
            chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(tx_tab[ei]));
        end
    endtask

    task automatic master_done(input int n_wait, input logic [7:0] rx);
        repeat (n_wait) @(negedge clk);
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = rx;
        @(negedge clk);
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = 8'hEE;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.rsp_valid == '0 && cyc < TO + 10);
    endtask

    task automatic check_rsp();
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_q_nonempty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << e[10:9]));
            chk("rsp_data",  32'(bus.rsp_data), 32'(e[7:0]));
            chk("rsp_err",   32'(bus.rsp_err), 32'(e[8]));
        end
        @(negedge clk);
        chk("rsp_pulse", 32'(bus.rsp_valid), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         cyc;
        int         seen;
        logic [7:0] rx;

        bus.req         = '0;
        bus.spi_busy    = 1'b0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = '0;
        for (int i = 0; i < NR; i++) tx_tab[i] = 8'h11 * (i + 1);

        do_reset();

        // Single request from 2; req/tx changes after the latch are ignored,
        // and requester 3 (raised meanwhile) is served next.
        tx_tab[2] = 8'hA5;
        bus.req   = 4'b0100;
        gnt_q.push_back(2'd2);
        grant_step(1);
        bus.req   = 4'b1000;
        tx_tab[2] = 8'hFF;
        push_rsp(2'd2, 1'b0, 8'h3C);
        @(negedge clk);
        chk("hold_tx",  32'(bus.spi_tx_data), 32'h0A5);
        chk("hold_sel", 32'(bus.spi_sel), 2);
        master_done(0, 8'h3C);
        check_rsp();
        gnt_q.push_back(2'd3);
        grant_step(1);
        bus.req = '0;
        push_rsp(2'd3, 1'b0, 8'hC3);
        master_done(2, 8'hC3);
        check_rsp();

        // Fairness with every request held, starting from reset.
        do_reset();
        for (int i = 0; i < NR; i++) tx_tab[i] = 8'h10 + 8'(i);
        bus.req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            gnt_q.push_back(2'(t % 4));
            // After check_rsp we sit in the idle cycle: next grant is one away.
            grant_step(1);
            if (t == 7) bus.req = '0;
            rx = 8'($urandom_range(0, 255));
            push_rsp(2'(t % 4), 1'b0, rx);
            master_done($urandom_range(1, 4), rx);
            check_rsp();
        end

        // Timeout: master never answers.
        bus.req = 4'b0001;
        gnt_q.push_back(2'd0);
        grant_step(1);
        bus.req         = '0;
        bus.spi_rx_data = 8'hFF;
        push_rsp(2'd0, 1'b1, 8'h00);
        wait_rsp(cyc);
        chk("timeout_cycles", cyc, TO + 1);
        check_rsp();

        // spi_done on the final timeout cycle wins.
        bus.req = 4'b0010;
        gnt_q.push_back(2'd1);
        grant_step(1);
        bus.req = '0;
        push_rsp(2'd1, 1'b0, 8'h5A);
        master_done(TO, 8'h5A);
        check_rsp();

        // spi_busy holds off arbitration.
        bus.spi_busy = 1'b1;
        bus.req      = 4'b0001;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.gnt != '0) seen++;
        end
        chk("busy_no_gnt", seen, 0);
        bus.spi_busy = 1'b0;
        gnt_q.push_back(2'd0);
        grant_step(1);
        bus.req = '0;
        push_rsp(2'd0, 1'b0, 8'h77);
        master_done(3, 8'h77);
        check_rsp();

        // spi_done in IDLE and in START is ignored.
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'h99;
        @(negedge clk);
        bus.spi_done = 1'b0;
        chk("idle_done_rsp",   32'(bus.rsp_valid), 0);
        chk("idle_done_state", 32'(dbg_state), 32'(ST_IDLE));
        bus.req = 4'b0100;
        gnt_q.push_back(2'd2);
        grant_step(1);
        bus.req         = '0;
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'h66;
        push_rsp(2'd2, 1'b1, 8'h00);
        @(negedge clk);
        bus.spi_done = 1'b0;
        wait_rsp(cyc);
        chk("start_done_ignored_cycles", cyc, TO);
        check_rsp();

        // Reset in WAIT aborts silently; a fresh request works afterwards.
        bus.req = 4'b0010;
        gnt_q.push_back(2'd1);
        grant_step(1);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("pre_abort_state", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort");
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        bus.req = 4'b0010;
        gnt_q.push_back(2'd1);
        grant_step(1);
        bus.req = '0;
        push_rsp(2'd1, 1'b0, 8'h81);
        master_done(1, 8'h81);
        check_rsp();

        chk("exp_q_drained", exp_q.size(), 0);
        chk("gnt_q_drained", gnt_q.size(), 0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
